// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard between ID issue and WB retirement; raises the ID stall.
// Optional flag-dependency tracking is built when HAZARD_SB_FLAGS_EN is defined.
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter bit WB_BYPASS    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic        id_s,
  input  logic [3:0]  id_cond,
  input  logic        freeze,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic        flags_commit,
  output logic        hazard,
  output logic        issue,
  output logic [15:0] busy,
  output logic [3:0]  inflight,
  output logic        underflow
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt     [16];
  logic [CW-1:0] cnt_nxt [16];
  logic [15:0]   busy_nxt;
  logic [3:0]    inflight_nxt;
  logic          underflow_nxt;
  logic          pend1, pend2, sat, fhaz;
  logic          inc, dec, same_reg;

`ifdef HAZARD_SB_FLAGS_EN
  logic [CW-1:0] fcnt, fcnt_nxt;
  assign fhaz = (id_cond != 4'b1110) && (fcnt != '0);
`else
  logic unused_flags;
  assign unused_flags = ^{id_s, id_cond, flags_commit};
  assign fhaz = 1'b0;
`endif

  // A register whose last pending write retires this cycle is readable through the write-through file.
  always_comb begin
    pend1 = (cnt[id_src1] != '0);
    if (WB_BYPASS && wb_en && (wb_dest == id_src1) && (cnt[id_src1] == CNT_ONE))
      pend1 = 1'b0;
    pend2 = (cnt[id_src2] != '0);
    if (WB_BYPASS && wb_en && (wb_dest == id_src2) && (cnt[id_src2] == CNT_ONE))
      pend2 = 1'b0;
    sat = id_wb_en && (cnt[id_dest] == CNT_MAX) && !(wb_en && (wb_dest == id_dest));
  end

  assign hazard   = id_valid & (pend1 | (id_two_src & pend2) | sat | fhaz);
  assign issue    = id_valid & ~hazard & ~freeze & ~flush;
  assign inc      = issue & id_wb_en;
  assign dec      = wb_en;
  assign same_reg = inc & dec & (id_dest == wb_dest);

  always_comb begin
    cnt_nxt       = cnt;
    inflight_nxt  = inflight;
    underflow_nxt = underflow;
    if (!same_reg) begin
      if (inc && (cnt[id_dest] != CNT_MAX)) begin
        cnt_nxt[id_dest] = cnt[id_dest] + CNT_ONE;
        inflight_nxt     = inflight_nxt + 4'd1;
      end
      if (dec) begin
        if (cnt[wb_dest] != '0) begin
          cnt_nxt[wb_dest] = cnt[wb_dest] - CNT_ONE;
          if (inflight_nxt != 4'd0)
            inflight_nxt = inflight_nxt - 4'd1;
        end else begin
          underflow_nxt = 1'b1;
        end
      end
    end
`ifdef HAZARD_SB_FLAGS_EN
    fcnt_nxt = fcnt;
    if (!(issue && id_s && flags_commit)) begin
      if (issue && id_s && (fcnt != CNT_MAX))
        fcnt_nxt = fcnt + CNT_ONE;
      if (flags_commit) begin
        if (fcnt != '0)
          fcnt_nxt = fcnt - CNT_ONE;
        else
          underflow_nxt = 1'b1;
      end
    end
`endif
    for (int r = 0; r < 16; r++)
      busy_nxt[r] = (cnt_nxt[r] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++)
        cnt[r] <= '0;
      busy      <= 16'd0;
      inflight  <= 4'd0;
      underflow <= 1'b0;
`ifdef HAZARD_SB_FLAGS_EN
      fcnt      <= '0;
`endif
    end else begin
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      inflight  <= inflight_nxt;
      underflow <= underflow_nxt;
`ifdef HAZARD_SB_FLAGS_EN
      fcnt      <= fcnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset/flag sequences, and a
// randomized run against a queue-based model of the writes in flight.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_two_src, id_wb_en, id_s;
  logic [3:0]  id_src1, id_src2, id_dest, id_cond;
  logic        freeze, flush, wb_en, flags_commit;
  logic [3:0]  wb_dest;
  logic        hazard, issue, underflow;
  logic [15:0] busy;
  logic [3:0]  inflight;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [3:0] s1, s2;
    logic       two, wen;
    logic [3:0] dst;
    logic       s;
    logic [3:0] cond;
    logic       frz, fl, wbe;
    logic [3:0] wbd;
    logic       fc;
    logic        exp_h, exp_i;
    logic [15:0] exp_busy;
    logic [3:0]  exp_inf;
    logic        exp_uf;
  } vec_t;

  vec_t tbl[24];
  int   q[$];
  int   fpend;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .id_s(id_s),
    .id_cond(id_cond), .freeze(freeze), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .flags_commit(flags_commit), .hazard(hazard), .issue(issue), .busy(busy),
    .inflight(inflight), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                              input logic two, input logic wen, input logic [3:0] dst,
                              input logic frz, input logic fl, input logic wbe,
                              input logic [3:0] wbd, input logic h, input logic i,
                              input logic [15:0] b, input logic [3:0] inf, input logic uf);
    vec_t t;
    t.v = v; t.s1 = s1; t.s2 = s2; t.two = two; t.wen = wen; t.dst = dst;
    t.s = 1'b0; t.cond = 4'hE; t.frz = frz; t.fl = fl; t.wbe = wbe; t.wbd = wbd; t.fc = 1'b0;
    t.exp_h = h; t.exp_i = i; t.exp_busy = b; t.exp_inf = inf; t.exp_uf = uf;
    return t;
  endfunction

  function automatic int qcount(input int r);
    int c = 0;
    foreach (q[k]) if (q[k] == r) c++;
    return c;
  endfunction

  // Readable means no write outstanding, or the only one retires now (write-through file).
  function automatic logic qpend(input int r, input logic we, input logic [3:0] wd);
    int c = qcount(r);
    if (c == 0) return 1'b0;
    if (we && (int'(wd) == r) && (c == 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    id_valid = t.v; id_src1 = t.s1; id_src2 = t.s2; id_two_src = t.two;
    id_wb_en = t.wen; id_dest = t.dst; id_s = t.s; id_cond = t.cond;
    freeze = t.frz; flush = t.fl; wb_en = t.wbe; wb_dest = t.wbd; flags_commit = t.fc;
  endtask

  task automatic runVector(input vec_t t, input string tag);
    applyStimulus(t);
    #1;
    checkOutput({tag, ".hazard"}, {15'd0, hazard}, {15'd0, t.exp_h});
    checkOutput({tag, ".issue"},  {15'd0, issue},  {15'd0, t.exp_i});
    @(posedge clk);
    #1;
    checkOutput({tag, ".busy"},      busy,                  t.exp_busy);
    checkOutput({tag, ".inflight"},  {12'd0, inflight},     {12'd0, t.exp_inf});
    checkOutput({tag, ".underflow"}, {15'd0, underflow},    {15'd0, t.exp_uf});
  endtask

  initial begin
    vec_t        t;
    logic        p1, p2, sat, fh, h, iss;
    logic [15:0] b;

    //            v  s1 s2 tw we dst fz fl wbe wbd  h  i  busy      inf uf
    tbl[0]  = mk(1, 0, 0, 0, 1, 5,  0, 0, 0, 0,  0, 1, 16'h0020, 1, 0);
    tbl[1]  = mk(1, 5, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 16'h0020, 1, 0);
    tbl[2]  = mk(1, 5, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 16'h0020, 1, 0);
    tbl[3]  = mk(1, 5, 0, 0, 0, 0,  0, 0, 1, 5,  0, 1, 16'h0000, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 2,  0, 0, 0, 0,  0, 1, 16'h0004, 1, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1, 2,  0, 0, 1, 2,  0, 1, 16'h0004, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2,  0, 0, 16'h0000, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 1, 7,  0, 0, 0, 0,  0, 1, 16'h0080, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 1, 7,  0, 0, 0, 0,  0, 1, 16'h0080, 2, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1, 7,  0, 0, 0, 0,  0, 1, 16'h0080, 3, 0);
    tbl[10] = mk(1, 0, 0, 0, 1, 7,  0, 0, 0, 0,  1, 0, 16'h0080, 3, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 7,  0, 0, 1, 7,  0, 1, 16'h0080, 3, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 7,  0, 0, 16'h0080, 2, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 7,  0, 0, 16'h0080, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 7,  0, 0, 16'h0000, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 1, 4,  0, 0, 0, 0,  0, 1, 16'h0010, 1, 0);
    tbl[16] = mk(1, 0, 0, 0, 1, 6,  1, 0, 1, 4,  0, 0, 16'h0000, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 1, 6,  0, 1, 0, 0,  0, 0, 16'h0000, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 9,  0, 0, 16'h0000, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 16'h0000, 0, 1);
    tbl[20] = mk(1, 0, 0, 0, 1, 1,  0, 0, 0, 0,  0, 1, 16'h0002, 1, 1);
    tbl[21] = mk(1, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 1, 16'h0002, 1, 1);
    tbl[22] = mk(1, 0, 1, 1, 0, 0,  0, 0, 0, 0,  1, 0, 16'h0002, 1, 1);
    tbl[23] = mk(1, 0, 1, 1, 0, 0,  0, 0, 1, 1,  0, 1, 16'h0000, 0, 1);

    rst = 1'b1;
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_wb_en = 0; id_dest = 0;
    id_s = 0; id_cond = 4'hE; freeze = 0; flush = 0; wb_en = 0; wb_dest = 0; flags_commit = 0;
    #1;
    checkOutput("reset.busy",      busy,               16'h0000);
    checkOutput("reset.inflight",  {12'd0, inflight},  16'h0000);
    checkOutput("reset.underflow", {15'd0, underflow}, 16'h0000);
    checkOutput("reset.hazard",    {15'd0, hazard},    16'h0000);
    checkOutput("reset.issue",     {15'd0, issue},     16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++)
      runVector(tbl[i], $sformatf("tbl[%0d]", i));

    // Mid-stream asynchronous reset with two writes pending on R3.
    runVector(mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 16'h0008, 1, 1), "rst_seq.a");
    runVector(mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 16'h0008, 2, 1), "rst_seq.b");
    @(negedge clk);
    id_valid = 0; id_wb_en = 0;
    rst = 1'b1;
    #1;
    checkOutput("rst_seq.busy",      busy,               16'h0000);
    checkOutput("rst_seq.inflight",  {12'd0, inflight},  16'h0000);
    checkOutput("rst_seq.underflow", {15'd0, underflow}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    runVector(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0), "rst_seq.read_r3");

`ifdef HAZARD_SB_FLAGS_EN
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0); t.s = 1'b1;
    runVector(t, "flags.set");
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0); t.cond = 4'h0;
    runVector(t, "flags.cond_wait");
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    runVector(t, "flags.al_free");
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0); t.cond = 4'h0; t.fc = 1'b1;
    runVector(t, "flags.commit");
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0); t.cond = 4'h0;
    runVector(t, "flags.cond_go");
`endif

    // Randomized run: the model holds in-flight writes as an ordered queue retired oldest-first.
    q.delete();
    fpend = 0;
    for (int n = 0; n < 400; n++) begin
      t = mk(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0, 4'd0,
             1'b0, 1'b0, 16'h0000, 4'd0, 1'b0);
      t.s    = 1'($urandom_range(0, 1));
      t.cond = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 13));
      if ((q.size() > 0) && ((q.size() >= 5) || ($urandom_range(0, 1) != 0))) begin
        t.wbe = 1'b1;
        t.wbd = 4'(q[0]);
      end
      t.fc = (fpend > 0) && ($urandom_range(0, 1) != 0);

      p1  = qpend(int'(t.s1), t.wbe, t.wbd);
      p2  = qpend(int'(t.s2), t.wbe, t.wbd);
      sat = t.wen && (qcount(int'(t.dst)) >= 3) && !(t.wbe && (t.wbd == t.dst));
      fh  = 1'b0;
`ifdef HAZARD_SB_FLAGS_EN
      fh  = (t.cond != 4'hE) && (fpend > 0);
`endif
      h   = t.v && (p1 || (t.two && p2) || sat || fh);
      iss = t.v && !h && !t.frz && !t.fl;

      if (t.wbe) void'(q.pop_front());
      if (iss && t.wen) q.push_back(int'(t.dst));
      if (iss && t.s && !t.fc) fpend = (fpend < 3) ? fpend + 1 : 3;
      else if (t.fc && !(iss && t.s)) fpend = fpend - 1;

      b = 16'h0000;
      for (int r = 0; r < 16; r++) b[r] = (qcount(r) > 0);
      t.exp_h = h; t.exp_i = iss; t.exp_busy = b; t.exp_inf = 4'(q.size()); t.exp_uf = 1'b0;
      runVector(t, $sformatf("rand[%0d]", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
